// File: rtl/seq_cnt_arb_pkg.sv
// rtl/seq_cnt_arb_pkg.sv - shared types, defaults and width helper for the seq_cnt_arb block
package seq_cnt_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int N_DEF       = 4;
    localparam int CNT_MAX_DEF = 4;
    localparam int TMO_DEF     = 16;

    // Never returns less than 1 so every derived vector has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_cnt_arb_if.sv
// rtl/seq_cnt_arb_if.sv - requester-side bundle between the lanes and the shared counting engine
interface seq_cnt_arb_if #(
    parameter int N = seq_cnt_pkg::N_DEF
);
    localparam int ID_W = seq_cnt_pkg::clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    data;
    logic [N-1:0]    grant;
    logic            flag;
    logic            err;
    logic            busy;
    logic [ID_W-1:0] done_id;

    modport master (
        output req, data,
        input  grant, flag, err, busy, done_id
    );

    modport slave (
        input  req, data,
        output grant, flag, err, busy, done_id
    );

endinterface

// File: rtl/seq_cnt_arb_rr_pick.sv
// rtl/seq_cnt_arb_rr_pick.sv - combinational round-robin winner search starting at ptr_i
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    always_comb begin
        int j;
        j       = 0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!valid_o && req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = W'(j);
            end
        end
    end

endmodule

// File: rtl/seq_cnt_arb.sv
// rtl/seq_cnt_arb.sv - round-robin owner of one shared ones-counter across N requesters
module seq_cnt_arb
    import seq_cnt_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int TMO     = TMO_DEF
) (
    input  logic         clk,
    input  logic         rst,
    seq_cnt_arb_if.slave bus
);

    localparam int ID_W  = clog2(N);
    localparam int CNT_W = clog2(CNT_MAX);
    localparam int TMO_W = clog2(TMO);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N - 1);

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic             flag_q, flag_d;
    logic             err_q, err_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tcnt_q, tcnt_d;

    logic [ID_W-1:0]  win_idx;
    logic             win_valid;
    logic [ID_W-1:0]  next_ptr;
    logic             lane_req;
    logic             lane_data;

    rr_pick #(
        .N (N),
        .W (ID_W)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    // The lane after the current owner gets first look next time, so a lane
    // that keeps requesting waits behind every other pending lane.
    assign next_ptr  = (idx_q == ID_LAST) ? '0 : idx_q + ID_W'(1);
    assign lane_req  = bus.req[idx_q];
    assign lane_data = bus.data[idx_q];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        flag_d    = 1'b0;
        err_d     = 1'b0;
        done_id_d = done_id_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d = ST_RUN;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    idx_d   = win_idx;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (!lane_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end else if (lane_data && (cnt_q == CNT_LAST)) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    flag_d    = 1'b1;
                    done_id_d = idx_q;
                end else if (tcnt_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    err_d     = 1'b1;
                    done_id_d = idx_q;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(lane_data);
                    tcnt_d = tcnt_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            flag_q    <= 1'b0;
            err_q     <= 1'b0;
            done_id_q <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            flag_q    <= flag_d;
            err_q     <= err_d;
            done_id_q <= done_id_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.flag    = flag_q;
    assign bus.err     = err_q;
    assign bus.done_id = done_id_q;
    assign bus.busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_seq_cnt_arb.sv
// tb/tb_seq_cnt_arb.sv - table-driven scoreboard bench for seq_cnt_arb (N=4, CNT_MAX=4, TMO=16)
module tb_seq_cnt_arb;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    seq_cnt_arb_if #(.N(4)) bus();

    seq_cnt_arb #(
        .N       (4),
        .CNT_MAX (4),
        .TMO     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] data;
        logic [3:0] grant;
        logic       flag;
        logic       err;
        logic [1:0] done_id;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                                input logic f, input logic e, input logic [1:0] id);
        vec_t v;
        v.req = r; v.data = d; v.grant = g; v.flag = f; v.err = e; v.done_id = id;
        vecs.push_back(v);
    endfunction

    task automatic check_vec(input string tag, input int row, input vec_t v);
        check($sformatf("%s[%0d].grant", tag, row), int'(bus.grant), int'(v.grant));
        check($sformatf("%s[%0d].flag", tag, row), int'(bus.flag), int'(v.flag));
        check($sformatf("%s[%0d].err", tag, row), int'(bus.err), int'(v.err));
        check($sformatf("%s[%0d].done_id", tag, row), int'(bus.done_id), int'(v.done_id));
        check($sformatf("%s[%0d].busy", tag, row), int'(bus.busy), int'(|v.grant));
    endtask

    // Each row is driven at a falling edge; its expectation is popped and
    // checked at the next falling edge, after the rising edge sampled it.
    task automatic run_vecs(input string tag);
        int row;
        row = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (sb.size() != 0) begin
                check_vec(tag, row, sb.pop_front());
                row++;
            end
            bus.req  = vecs[i].req;
            bus.data = vecs[i].data;
            sb.push_back(vecs[i]);
        end
        @(negedge clk);
        check_vec(tag, row, sb.pop_front());
        bus.req  = '0;
        bus.data = '0;
        vecs.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        bus.req  = '0;
        bus.data = '0;
        #1;
        check("reset.grant", int'(bus.grant), 0);
        check("reset.flag", int'(bus.flag), 0);
        check("reset.err", int'(bus.err), 0);
        check("reset.busy", int'(bus.busy), 0);
        check("reset.done_id", int'(bus.done_id), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bus.req  = '0;
        bus.data = '0;

        do_reset();
        add(4'b0010, 4'b0000, 4'b0010, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(4'b0010, 4'b0010, 4'b0010, 0, 0, 0);
        add(4'b0010, 4'b0010, 4'b0000, 1, 0, 1);
        add(4'b0000, 4'b0000, 4'b0000, 0, 0, 1);
        run_vecs("basic");

        do_reset();
        for (int l = 0; l < 4; l++) begin
            for (int r = 0; r < 4; r++)
                add(4'hF, 4'hF, 4'(4'b0001 << l), 0, 0, (l == 0) ? 2'd0 : 2'(l - 1));
            add(4'hF, 4'hF, 4'b0000, 1, 0, 2'(l));
        end
        add(4'hF, 4'hF, 4'b0001, 0, 0, 3);
        add(4'h0, 4'h0, 4'b0000, 0, 0, 3);
        add(4'h0, 4'h0, 4'b0000, 0, 0, 3);
        run_vecs("rr");

        do_reset();
        add(4'b0100, 4'b0001, 4'b0100, 0, 0, 0);
        add(4'b0100, 4'b0100, 4'b0100, 0, 0, 0);
        add(4'b0100, 4'b0001, 4'b0100, 0, 0, 0);
        add(4'b0100, 4'b0100, 4'b0100, 0, 0, 0);
        add(4'b0100, 4'b0001, 4'b0100, 0, 0, 0);
        add(4'b0100, 4'b0100, 4'b0100, 0, 0, 0);
        add(4'b0100, 4'b0101, 4'b0000, 1, 0, 2);
        add(4'b0000, 4'b0000, 4'b0000, 0, 0, 2);
        run_vecs("sparse");

        do_reset();
        add(4'b1000, 4'b0000, 4'b1000, 0, 0, 0);
        add(4'b1000, 4'b1000, 4'b1000, 0, 0, 0);
        add(4'b1000, 4'b1000, 4'b1000, 0, 0, 0);
        add(4'b0000, 4'b1000, 4'b0000, 0, 0, 0);
        add(4'b1001, 4'b0000, 4'b0001, 0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        run_vecs("withdraw");

        do_reset();
        add(4'b0010, 4'b0000, 4'b0010, 0, 0, 0);
        for (int k = 0; k < 15; k++) add(4'b0110, 4'b0000, 4'b0010, 0, 0, 0);
        add(4'b0110, 4'b0000, 4'b0000, 0, 1, 1);
        add(4'b0110, 4'b0000, 4'b0100, 0, 0, 1);
        add(4'b0000, 4'b0000, 4'b0000, 0, 0, 1);
        run_vecs("timeout");

        // Asynchronous reset while the grant is in its second cycle.
        do_reset();
        @(negedge clk);
        bus.req  = 4'b0001;
        bus.data = 4'b0001;
        @(negedge clk);
        check("areset.grant_on", int'(bus.grant), 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("areset.grant_async", int'(bus.grant), 0);
        check("areset.busy_async", int'(bus.busy), 0);
        check("areset.flag_async", int'(bus.flag), 0);
        bus.req  = '0;
        bus.data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("areset.grant_idle", int'(bus.grant), 0);
        check("areset.busy_idle", int'(bus.busy), 0);
        check("areset.flag_idle", int'(bus.flag), 0);
        check("areset.err_idle", int'(bus.err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_cnt_arb.md
# seq_cnt_arb

Round-robin scheduler that shares one ones-counting engine between N requesters. The block grants the engine to one requester at a time and counts that requester's `data` high cycles. After CNT_MAX highs it raises a one-cycle `flag`, tagged with the requester index, then releases the grant. It sits in front of the pulse-counting datapath and replaces the per-requester copies of the counting FSM.

## Interface
- `N`, default 4, number of requesters (2..16).
- `CNT_MAX`, default 4, number of `data` highs per grant that produce `flag` (2..256).
- `TMO`, default 16, maximum cycles a grant may be held in RUN before it is aborted (must be > CNT_MAX).

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req` input N: level request per requester; held high for as long as the requester wants the engine.
- `data` input N: per-requester data bit; only the granted lane is counted.
- `grant` output N: registered one-hot grant, all zeros when idle.
- `flag` output 1: registered one-cycle pulse when the granted lane reaches CNT_MAX highs.
- `done_id` output clog2(N): index of the lane that produced the last `flag` or `err`; holds until the next event.
- `err` output 1: registered one-cycle pulse on timeout abort.
- `busy` output 1: high while in RUN, equal to `|grant`.

## Operation
- States are IDLE and RUN, held in a registered state register.
- Round-robin pointer `ptr`, width clog2(N): the winner is the first `req` bit found searching from `ptr` upward, wrapping from N-1 to 0.
- IDLE:
  - If `req != 0` at an edge: go to RUN, `grant <= onehot(winner)`, `idx <= winner`, `cnt <= 0`, `tcnt <= 0`.
  - Otherwise stay in IDLE.
- RUN, evaluated every edge in this priority order:
  1. `!req[idx]`: withdrawal abort. Go to IDLE, `grant <= 0`, `ptr <= idx+1 mod N`. No `flag`, no `err`.
  2. `data[idx] && cnt == CNT_MAX-1`: `flag <= 1`, `done_id <= idx`, `grant <= 0`, `ptr <= idx+1 mod N`, go to IDLE.
  3. `tcnt == TMO-1`: `err <= 1`, `done_id <= idx`, `grant <= 0`, `ptr <= idx+1 mod N`, go to IDLE.
  4. Otherwise: `cnt <= cnt + data[idx]`, `tcnt <= tcnt + 1`.
- `flag` and `err` are cleared on every edge where they are not set. They are never high in the same cycle.
- `data` on non-granted lanes is ignored. `cnt` never wraps inside a grant; it is reset to 0 at each grant.
- Width rules:
  - `cnt` is clog2(CNT_MAX) bits.
  - `tcnt` is clog2(TMO) bits.
  - `ptr+1` wraps to 0 when N is not a power of two.
- Reset values: state IDLE, `grant` 0, `flag` 0, `err` 0, `busy` 0, `done_id` 0, `ptr` 0, `cnt` 0, `tcnt` 0.
- Reset asserted in RUN drops `grant` immediately (asynchronously). No `flag` is produced for the partial count.

## Timing
- Grant latency: `req` sampled high at edge k gives `grant` high from edge k. The first counted `data` is sampled at edge k+1.
- `flag` rises on the same edge that samples the CNT_MAX-th high, and `grant` falls on that edge.
- Minimum one IDLE cycle between consecutive grants, so back-to-back grants to different lanes are 1 cycle apart.
- Fully continuous `data` on the granted lane gives `flag` CNT_MAX cycles after `grant` rises.
- A requester keeping `req` high after `flag` is re-granted only after all other pending lanes have been served (fairness).
- Timeout: `err` appears TMO cycles after `grant` rises if fewer than CNT_MAX highs were seen.

## Structure
- Package `seq_cnt_pkg` holds:
  - the state encoding (IDLE, RUN) as a typedef;
  - a clog2 helper function;
  - the default parameter constants.
- Sub-module `rr_pick` is combinational. Inputs are `req` and `ptr`; outputs are the winner index and a `valid` bit. It is reused by other arbiters in the design.
- Top level holds the state register, counters, `ptr` and all output registers.

## Test plan
- Reset/basic: `rst` low, then `req=4'b0010`, `data[1]` high 4 cycles. `grant=4'b0010` for 4 cycles, `flag` for 1 cycle, `done_id=1`, then `grant=0`.
- Round-robin: `req=4'b1111` held, all `data` high. Grants go lane 0,1,2,3,0 in order, each 4 cycles with a 1-cycle gap. `done_id` sequence is 0,1,2,3.
- Sparse data: lane 2 granted, `data[2]` pattern 1,0,1,0,1,1. `flag` on the 6th sampled cycle. `data[0]` toggling throughout has no effect.
- Withdrawal: lane 3 granted, 2 highs counted, then `req[3]` drops in the same cycle as `data[3]=1`. Grant drops, no `flag`, no `err`, `ptr=0`.
- Timeout: lane 1 granted with `data[1]=0` constant and TMO=16. `err` pulses 16 cycles after `grant`, `done_id=1`, and the next grant goes to lane 2 if it is requesting.
- Async reset mid-run: `rst` low during cycle 2 of a grant. `grant`, `busy` and state clear without waiting for a clock edge. After release with `req=0`, the block stays in IDLE.
